// File: rtl/ripple_chunk_sequencer.sv
// ripple_chunk_sequencer: feeds WIDTH-bit operands to a 2-bit ripple adder slice, LSB chunk first, and assembles the sum.
module ripple_chunk_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             cin,
  output logic [1:0]       sliceA,
  output logic [1:0]       sliceB,
  output logic             sliceCarryIn,
  input  logic [1:0]       sliceSum,
  input  logic             sliceCarry,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] sum,
  output logic             carryOut
);
  localparam int N = WIDTH / 2;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic carry_q, carry_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [WIDTH+1:0] shift_in;
  logic run;
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    sum_d = sum_q;
    carry_d = carry_q;
    idx_d = idx_q;
    // new chunk enters at the top so the LSB chunk lands at bit 0 after N shifts
    shift_in = {sliceSum, sum_q};
    if (state_q == IDLE && inValid) begin
      a_d = opA;
      b_d = opB;
      carry_d = cin;
      idx_d = '0;
      state_d = RUN;
    end else if (state_q == RUN) begin
      sum_d = shift_in[WIDTH+1:2];
      carry_d = sliceCarry;
      a_d = a_q >> 2;
      b_d = b_q >> 2;
      idx_d = idx_q + IW'(1);
      state_d = idx_q == IW'(N - 1) ? DONE : RUN;
    end else if (state_q == DONE && outReady) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      sum_q <= '0;
      carry_q <= 1'b0;
      idx_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      sum_q <= sum_d;
      carry_q <= carry_d;
      idx_q <= idx_d;
    end
  end
  assign run = state_q == RUN;
  assign inReady = state_q == IDLE;
  assign outValid = state_q == DONE;
  assign sliceA = run ? a_q[1:0] : 2'b0;
  assign sliceB = run ? b_q[1:0] : 2'b0;
  assign sliceCarryIn = run ? carry_q : 1'b0;
  assign sum = sum_q;
  assign carryOut = carry_q;
endmodule

// File: tb/tb_ripple_chunk_sequencer.sv
// tb_ripple_chunk_sequencer: directed scoreboard bench with a behavioural 2-bit ripple slice on the slice ports.
module tb_ripple_chunk_sequencer;
  logic clk = 0, reset = 1, inValid = 0, outReady = 0, cin = 0;
  logic [7:0] opA = 0, opB = 0, sum;
  logic inReady, outValid, carryOut, sliceCarryIn, sliceCarry;
  logic [1:0] sliceA, sliceB, sliceSum;
  logic [8:0] q[$];
  logic [8:0] exp_r;
  int total = 0, passed = 0;

  ripple_chunk_sequencer #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
    .opA(opA), .opB(opB), .cin(cin),
    .sliceA(sliceA), .sliceB(sliceB), .sliceCarryIn(sliceCarryIn),
    .sliceSum(sliceSum), .sliceCarry(sliceCarry),
    .outValid(outValid), .outReady(outReady), .sum(sum), .carryOut(carryOut)
  );

  assign {sliceCarry, sliceSum} = 3'(sliceA) + 3'(sliceB) + 3'(sliceCarryIn);

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                       input int hold, input bit poke);
    logic c;
    logic [2:0] s;
    logic [8:0] res;
    chk("idle_inReady", inReady, 1);
    opA = a; opB = b; cin = ci; inValid = 1; outReady = 0;
    q.push_back(9'(a) + 9'(b) + 9'(ci));
    step();
    inValid = 0;
    opA = 8'($urandom); opB = 8'($urandom); cin = 1'($urandom);
    c = ci;
    for (int i = 0; i < 4; i++) begin
      chk("run_sliceA", sliceA, (a >> (2 * i)) & 8'h3);
      chk("run_sliceB", sliceB, (b >> (2 * i)) & 8'h3);
      chk("run_sliceCarryIn", sliceCarryIn, c);
      chk("run_outValid", outValid, 0);
      chk("run_inReady", inReady, 0);
      s = 3'((a >> (2 * i)) & 8'h3) + 3'((b >> (2 * i)) & 8'h3) + 3'(c);
      c = s[2];
      if (poke && i == 1) inValid = 1;
      step();
      inValid = 0;
    end
    chk("latency_outValid", outValid, 1);
    exp_r = q.pop_front();
    res = {carryOut, sum};
    chk("result", res, exp_r);
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_outValid", outValid, 1);
      chk("hold_result", {carryOut, sum}, res);
      chk("hold_inReady", inReady, 0);
    end
    outReady = 1;
    chk("done_inReady_with_outReady", inReady, 0);
    step();
    outReady = 0;
    chk("post_outValid", outValid, 0);
  endtask

  initial begin
    logic [7:0] ba[3], bb[3];
    logic bc[3];
    int acc_cyc[$];
    int sent, got;
    step(); step();
    reset = 0;
    chk("rst_inReady", inReady, 1);
    chk("rst_outValid", outValid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_carryOut", carryOut, 0);
    chk("rst_slices", {sliceA, sliceB, sliceCarryIn}, 0);
    // basic, full ripple, overflow, stale-carry check
    do_op(8'h5A, 8'h3C, 1'b0, 0, 0);
    do_op(8'hFF, 8'h00, 1'b1, 0, 0);
    do_op(8'hFF, 8'h01, 1'b0, 0, 0);
    do_op(8'h00, 8'h00, 1'b0, 0, 0);
    // backpressure with an ignored mid-run offer
    do_op(8'hC7, 8'h9E, 1'b1, 3, 1);
    // reset in the second RUN cycle
    opA = 8'hAA; opB = 8'h55; cin = 0; inValid = 1;
    step();
    inValid = 0;
    step();
    reset = 1;
    step();
    reset = 0;
    chk("midrst_inReady", inReady, 1);
    chk("midrst_outValid", outValid, 0);
    chk("midrst_sum", sum, 0);
    chk("midrst_carryOut", carryOut, 0);
    chk("midrst_slices", {sliceA, sliceB, sliceCarryIn}, 0);
    do_op(8'h12, 8'h34, 1'b0, 0, 0);
    // back-to-back with inValid and outReady held high
    ba = '{8'h80, 8'h7F, 8'hC3};
    bb = '{8'h80, 8'h01, 8'h3D};
    bc = '{1'b1, 1'b1, 1'b0};
    sent = 0; got = 0;
    opA = ba[0]; opB = bb[0]; cin = bc[0]; inValid = 1; outReady = 1;
    for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
      if (outValid) begin
        exp_r = q.pop_front();
        chk("b2b_result", {carryOut, sum}, exp_r);
        got++;
      end
      if (inReady && inValid) begin
        q.push_back(9'(opA) + 9'(opB) + 9'(cin));
        acc_cyc.push_back(cyc);
        sent++;
      end
      step();
      if (sent < 3) begin
        opA = ba[sent]; opB = bb[sent]; cin = bc[sent];
      end else inValid = 0;
    end
    chk("b2b_results_seen", got, 3);
    chk("b2b_accepts_seen", acc_cyc.size(), 3);
    for (int i = 1; i < acc_cyc.size(); i++)
      chk("b2b_accept_spacing", acc_cyc[i] - acc_cyc[i-1], 6);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
